// File: rtl/census_pkg.sv
// Shared types and constants for the census cost arbiter and its helpers.
package census_pkg;

   localparam int WIDTH_DEF   = 64;
   localparam int NREQ_DEF    = 4;
   localparam int COST_W      = $clog2(WIDTH_DEF);
   localparam int ID_W        = $clog2(NREQ_DEF);
   localparam int STATS_CNT_W = 16;

   typedef logic [ID_W-1:0] census_id_t;

   // Saturating increment: sticks at all-ones instead of wrapping.
   function automatic logic [STATS_CNT_W-1:0] sat_inc(input logic [STATS_CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/census_cost_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping mod N.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  grant_o,
   output logic [IW-1:0] grant_idx_o,
   output logic          grant_any_o
);

   int c;

   always_comb begin
      grant_o     = '0;
      grant_idx_o = '0;
      grant_any_o = 1'b0;
      c           = 0;
      for (int k = 0; k < N; k++) begin
         c = (int'(ptr_i) + k) % N;
         if (!grant_any_o && req_i[c]) begin
            grant_o[c]  = 1'b1;
            grant_idx_o = IW'(c);
            grant_any_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/census_cost_arbiter.sv
// Shares one pipelined pop_count between NREQ census-cost requesters, tagging results with the requester ID.
// Optional per-requester grant counters when CENSUS_COST_ARB_STATS_EN is defined.
module census_cost_arbiter
   import census_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int NREQ  = 4,
   parameter int LAT   = 1,
   parameter int CW    = $clog2(WIDTH),
   parameter int IW    = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic [NREQ-1:0]       req_ready,
   input  logic                  flush,
   output logic [WIDTH-1:0]      pc_inp,
   input  logic [CW-1:0]         pc_outp,
   output logic                  resp_valid,
   output logic [IW-1:0]         resp_id,
   output logic [CW-1:0]         resp_count,
   output logic                  busy
`ifdef CENSUS_COST_ARB_STATS_EN
   ,
   output logic [NREQ*STATS_CNT_W-1:0] stat_grants
`endif
);

   logic [NREQ-1:0]  gnt;
   logic [IW-1:0]    gnt_idx;
   logic             gnt_any;
   logic             issue;
   logic [IW-1:0]    ptr_q, ptr_d;
   logic [WIDTH-1:0] pc_inp_q, opnd_d;
   logic [LAT:0]     vld_q;
   logic [IW-1:0]    id_q [LAT+1];

   rr_arbiter #(.N(NREQ), .IW(IW)) u_rr (
      .req_i       (req_valid),
      .ptr_i       (ptr_q),
      .grant_o     (gnt),
      .grant_idx_o (gnt_idx),
      .grant_any_o (gnt_any)
   );

   always_comb begin
      issue     = gnt_any & ~flush & ~rst;
      req_ready = issue ? gnt : '0;
      ptr_d     = (gnt_idx == IW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
      opnd_d    = req_a[int'(gnt_idx)*WIDTH +: WIDTH] ^ req_b[int'(gnt_idx)*WIDTH +: WIDTH];
   end

   // Issue register plus a {valid,id} tag chain that tracks the pop_count latency.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q    <= '0;
         pc_inp_q <= '0;
         vld_q    <= '0;
         for (int k = 0; k <= LAT; k++) id_q[k] <= '0;
      end else begin
         if (issue) begin
            ptr_q    <= ptr_d;
            pc_inp_q <= opnd_d;
         end
         vld_q[0] <= issue;
         id_q[0]  <= gnt_idx;
         for (int k = 1; k <= LAT; k++) begin
            vld_q[k] <= vld_q[k-1] & ~flush;
            id_q[k]  <= id_q[k-1];
         end
      end
   end

   always_comb begin
      pc_inp     = pc_inp_q;
      resp_valid = vld_q[LAT];
      resp_id    = id_q[LAT];
      resp_count = pc_outp;
      busy       = |vld_q;
   end

`ifdef CENSUS_COST_ARB_STATS_EN
   logic [STATS_CNT_W-1:0] cnt_q [NREQ];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < NREQ; i++)
            if (issue && gnt[i]) cnt_q[i] <= sat_inc(cnt_q[i]);
      end
   end

   always_comb begin
      stat_grants = '0;
      for (int i = 0; i < NREQ; i++) stat_grants[i*STATS_CNT_W +: STATS_CNT_W] = cnt_q[i];
   end
`endif

endmodule

// File: tb/tb_census_cost_arbiter.sv
// Directed bench for census_cost_arbiter with a behavioural LAT=1 pop_count.
module tb_census_cost_arbiter;

   localparam int WIDTH = 64;
   localparam int NREQ  = 4;
   localparam int LAT   = 1;
   localparam int CW    = 6;
   localparam int IW    = 2;

   logic                  clk;
   logic                  rst;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic [NREQ-1:0]       req_ready;
   logic                  flush;
   logic [WIDTH-1:0]      pc_inp;
   logic [CW-1:0]         pc_outp;
   logic                  resp_valid;
   logic [IW-1:0]         resp_id;
   logic [CW-1:0]         resp_count;
   logic                  busy;
`ifdef CENSUS_COST_ARB_STATS_EN
   logic [NREQ*16-1:0]    stat_grants;
`endif

   int n_vec = 0;
   int n_bad = 0;

   census_cost_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .LAT(LAT), .CW(CW), .IW(IW)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_ready  (req_ready),
      .flush      (flush),
      .pc_inp     (pc_inp),
      .pc_outp    (pc_outp),
      .resp_valid (resp_valid),
      .resp_id    (resp_id),
      .resp_count (resp_count),
      .busy       (busy)
`ifdef CENSUS_COST_ARB_STATS_EN
      ,
      .stat_grants(stat_grants)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Shared pop_count stand-in: one register stage, result truncated to CW bits.
   always @(posedge clk) pc_outp <= CW'($countones(pc_inp));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [63:0] a, input logic [63:0] b);
      req_a[i*WIDTH +: WIDTH] = a;
      req_b[i*WIDTH +: WIDTH] = b;
   endtask

   logic [3:0] exp_rdy;

   initial begin
      rst = 1'b1; flush = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
      #12;
      chk("rst_ready", 64'(req_ready), 64'h0);
      chk("rst_pc_inp", pc_inp, 64'h0);
      chk("rst_resp_valid", 64'(resp_valid), 64'h0);
      chk("rst_resp_id", 64'(resp_id), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
      step();
      rst = 1'b0;
      step();

      // Single request from requester 2
      set_req(2, 64'hFF, 64'h0F);
      req_valid = 4'b0100;
      #1;
      chk("single_ready", 64'(req_ready), 64'h4);
      chk("single_rv0", 64'(resp_valid), 64'h0);
      step();
      req_valid = '0;
      #1;
      chk("single_pc_inp", pc_inp, 64'hF0);
      chk("single_busy", 64'(busy), 64'h1);
      chk("single_rv1", 64'(resp_valid), 64'h0);
      step();
      chk("single_rv2", 64'(resp_valid), 64'h1);
      chk("single_id", 64'(resp_id), 64'h2);
      chk("single_cnt", 64'(resp_count), 64'h4);
      step();
      chk("single_rv3", 64'(resp_valid), 64'h0);
      chk("single_busy_end", 64'(busy), 64'h0);

      // All four requesters from reset; requester i has popcount i+1
      rst = 1'b1;
      #2;
      rst = 1'b0;
      for (int i = 0; i < NREQ; i++) set_req(i, (64'h1 << (i + 1)) - 64'h1, 64'h0);
      for (int c = 0; c < 7; c++) begin
         req_valid = (c < 4) ? 4'hF : 4'h0;
         #1;
         exp_rdy = (c < 4) ? (4'b0001 << c) : 4'b0000;
         chk("all4_ready", 64'(req_ready), 64'(exp_rdy));
         chk("all4_rv", 64'(resp_valid), (c >= 2 && c < 6) ? 64'h1 : 64'h0);
         if (c >= 2 && c < 6) begin
            chk("all4_id", 64'(resp_id), 64'(c - 2));
            chk("all4_cnt", 64'(resp_count), 64'(c - 1));
         end
         chk("all4_busy", 64'(busy), (c >= 1 && c < 6) ? 64'h1 : 64'h0);
         step();
      end

      // Fairness between requesters 0 and 3
      for (int c = 0; c < 6; c++) begin
         req_valid = (c < 4) ? 4'b1001 : 4'b0000;
         #1;
         exp_rdy = (c >= 4) ? 4'b0000 : ((c % 2 == 0) ? 4'b0001 : 4'b1000);
         chk("fair_ready", 64'(req_ready), 64'(exp_rdy));
         if (c >= 2) begin
            chk("fair_rv", 64'(resp_valid), 64'h1);
            chk("fair_id", 64'(resp_id), (c % 2 == 0) ? 64'h0 : 64'h3);
            chk("fair_cnt", 64'(resp_count), (c % 2 == 0) ? 64'h1 : 64'h4);
         end
         step();
      end

      // Flush one cycle after the second of two back-to-back grants
      set_req(1, 64'h3, 64'h0);
      set_req(2, 64'hF0F0, 64'h0F0F);
      req_valid = 4'b0110;
      #1;
      chk("fl_ready0", 64'(req_ready), 64'h2);
      step();
      chk("fl_ready1", 64'(req_ready), 64'h4);
      step();
      flush = 1'b1;
      req_valid = 4'b0001;
      #1;
      chk("fl_ready_flush", 64'(req_ready), 64'h0);
      chk("fl_rv_first", 64'(resp_valid), 64'h1);
      chk("fl_id_first", 64'(resp_id), 64'h1);
      chk("fl_cnt_first", 64'(resp_count), 64'h2);
      step();
      flush = 1'b0;
      set_req(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
      #1;
      chk("fl_rv_suppressed", 64'(resp_valid), 64'h0);
      chk("fl_busy_after", 64'(busy), 64'h0);
      chk("fl_pc_inp_hold", pc_inp, 64'hFFFF);
      chk("fl_pending_grant", 64'(req_ready), 64'h1);
      step();
      req_valid = '0;
      #1;
      chk("ones_pc_inp", pc_inp, 64'hFFFF_FFFF_FFFF_FFFF);
      step();
      chk("ones_rv", 64'(resp_valid), 64'h1);
      chk("ones_id", 64'(resp_id), 64'h0);
      chk("ones_cnt_wrap", 64'(resp_count), 64'h0);
      step();

      // Asynchronous reset with ptr at 3 and an operation in flight
      req_valid = 4'b0100;
      #1;
      chk("ar_ready0", 64'(req_ready), 64'h4);
      step();
      req_valid = 4'b1010;
      #1;
      chk("ar_ready_ptr3", 64'(req_ready), 64'h8);
      chk("ar_busy_pre", 64'(busy), 64'h1);
      rst = 1'b1;
      #1;
      chk("ar_ready_rst", 64'(req_ready), 64'h0);
      chk("ar_busy_rst", 64'(busy), 64'h0);
      chk("ar_rv_rst", 64'(resp_valid), 64'h0);
      step();
      #1;
      rst = 1'b0;
      #1;
      chk("ar_first_grant", 64'(req_ready), 64'h2);
      step();
      req_valid = '0;
      #1;
      chk("ar_pc_inp", pc_inp, 64'h3);
      step();
      chk("ar_rv", 64'(resp_valid), 64'h1);
      chk("ar_id", 64'(resp_id), 64'h1);
      chk("ar_cnt", 64'(resp_count), 64'h2);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
